// File: rtl/obi_mem_secondary.sv
// OBI responder backed by a single-port word memory; responses return in order through a small FIFO.
// Latency: handshake in cycle N, response visible in cycle N+1 at the earliest.
// Backpressure: rready low fills the response FIFO; gnt drops while it is full (no same-cycle pass-through).
// Optional build macro OBI_MEM_WAIT_STATES_EN inserts WAIT_CYCLES grant wait states per request.
module obi_mem_secondary #(
    parameter int DEPTH       = 256,
    parameter int RSP_DEPTH   = 2,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RSP_DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   rsp_q [RSP_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] idx;
    logic          fifo_free;
    logic          push;
    logic          pop;
    logic [31:0]   push_dat;
    logic          unused_bits;

    // Byte-offset and out-of-range address bits are deliberately dropped, so addresses alias.
    assign idx         = addr_i[AW+1:2];
    assign unused_bits = ^{addr_i[31:AW+2], addr_i[1:0], WAIT_CYCLES[0]};

    assign fifo_free = (count_q != CNT_FULL);

`ifdef OBI_MEM_WAIT_STATES_EN
    localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_CYCLES);

    logic [WW-1:0] wcnt_q;

    // Count stalled request cycles; saturates at WAIT_MAX, so a full FIFO holds it there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
        end else if (!req_i || push) begin
            wcnt_q <= '0;
        end else if (wcnt_q != WAIT_MAX) begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    assign gnt_o = !rst_i && req_i && (wcnt_q == WAIT_MAX) && fifo_free;
`else
    // Grant is purely a function of FIFO room; reset gating keeps it low while rst_i is high.
    assign gnt_o = !rst_i && fifo_free;
`endif

    assign push     = req_i && gnt_o;
    assign rvalid_o = !rst_i && (count_q != '0);
    assign pop      = rvalid_o && rready_i;
    assign rdata_o  = rvalid_o ? rsp_q[rptr_q] : 32'h0;

    // Read data is captured at the handshake edge; writes answer with zero.
    assign push_dat = we_i ? 32'h0 : mem_q[idx];

    // Byte-enabled memory write; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push && we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response storage; only the pointers and count need reset to discard queued entries.
    always_ff @(posedge clk_i) begin
        if (push) begin
            rsp_q[wptr_q] <= push_dat;
        end
    end

    // Circular-buffer pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_mem_secondary.sv
// Directed bench for obi_mem_secondary: per-cycle vector table plus backpressure, reset and wait-state sequences.
// Latency: each step drives inputs on the falling edge and compares outputs 1 time unit later.
// Backpressure: exercised with rready held low until the two-entry FIFO is full.
module tb_obi_mem_secondary;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rready;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } vec_t;

    vec_t vq[$];

    always #5 clk_i = ~clk_i;

    obi_mem_secondary #(
        .DEPTH      (256),
        .RSP_DEPTH  (2),
        .WAIT_CYCLES(2)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .rdata_o (rdata_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic rr, input logic eg, input logic ev,
                        input logic [31:0] ed, input string nm);
        @(negedge clk_i);
        req_i    = r;
        addr_i   = a;
        we_i     = w;
        be_i     = b;
        wdata_i  = d;
        rready_i = rr;
        #1;
        chk({nm, ".gnt"},    {31'b0, gnt_o},    {31'b0, eg});
        chk({nm, ".rvalid"}, {31'b0, rvalid_o}, {31'b0, ev});
        chk({nm, ".rdata"},  rdata_o,           ed);
    endtask

    function automatic vec_t mkv(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                                 input logic [31:0] d, input logic rr, input logic eg, input logic ev,
                                 input logic [31:0] ed);
        vec_t v;
        v.req = r; v.addr = a; v.we = w; v.be = b; v.wdata = d;
        v.rready = rr; v.gnt = eg; v.rvalid = ev; v.rdata = ed;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i    = 1'b1;
        req_i    = 1'b0;
        addr_i   = 32'h0;
        we_i     = 1'b0;
        be_i     = 4'h0;
        wdata_i  = 32'h0;
        rready_i = 1'b1;
        #12;
        chk("rst.gnt",    {31'b0, gnt_o},    32'h0);
        chk("rst.rvalid", {31'b0, rvalid_o}, 32'h0);
        chk("rst.rdata",  rdata_o,           32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

`ifdef OBI_MEM_WAIT_STATES_EN
        // Write with two wait states, then its response.
        step(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, "ws_wr_c0");
        step(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, "ws_wr_c1");
        step(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0, "ws_wr_c2");
        step(1'b0, 32'h0,  1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0, "ws_wr_rsp");
        // Read asserted at cycle 0: granted in cycle 2 only, response valid in cycle 3.
        step(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        "ws_rd_c0");
        step(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        "ws_rd_c1");
        step(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,        "ws_rd_c2");
        step(1'b0, 32'h0,  1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, "ws_rd_c3");
        step(1'b0, 32'h0,  1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        "ws_idle");
`else
        // One row per cycle; expectations reflect state after the previous edge.
        vq.push_back(mkv(1'b1, 32'h10,  1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0));
        vq.push_back(mkv(1'b1, 32'h10,  1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0));
        vq.push_back(mkv(1'b0, 32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF));
        vq.push_back(mkv(1'b1, 32'h20,  1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0));
        vq.push_back(mkv(1'b1, 32'h20,  1'b1, 4'h5, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'h0));
        vq.push_back(mkv(1'b1, 32'h20,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0));
        vq.push_back(mkv(1'b0, 32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFF34FF78));
        vq.push_back(mkv(1'b1, 32'h404, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h0));
        vq.push_back(mkv(1'b1, 32'h004, 1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0));
        vq.push_back(mkv(1'b1, 32'h30,  1'b1, 4'hF, 32'h11223344, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5));
        vq.push_back(mkv(1'b1, 32'h31,  1'b1, 4'hA, 32'hAABBCCDD, 1'b1, 1'b1, 1'b1, 32'h0));
        vq.push_back(mkv(1'b1, 32'h33,  1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0));
        vq.push_back(mkv(1'b0, 32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hAA22CC44));
        vq.push_back(mkv(1'b0, 32'h0,   1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0));

        foreach (vq[i]) begin
            step(vq[i].req, vq[i].addr, vq[i].we, vq[i].be, vq[i].wdata, vq[i].rready,
                 vq[i].gnt, vq[i].rvalid, vq[i].rdata, $sformatf("vec%0d", i));
        end

        // Backpressure: two grants with rready low, full FIFO blocks even while popping.
        step(1'b1, 32'h10,  1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        "bp_a");
        step(1'b1, 32'h20,  1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "bp_b");
        step(1'b1, 32'h004, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, "bp_full");
        step(1'b1, 32'h004, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, "bp_pop1");
        step(1'b1, 32'h004, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFF34FF78, "bp_regnt");
        step(1'b0, 32'h0,   1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, "bp_third");
        step(1'b0, 32'h0,   1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,        "bp_empty");

        // Reset with two responses queued: outputs drop immediately, nothing stale afterwards.
        step(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,        "rm_fill0");
        step(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, "rm_fill1");
        step(1'b0, 32'h0,  1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, "rm_full");
        rst_i = 1'b1;
        #1;
        chk("rm_rst.gnt",    {31'b0, gnt_o},    32'h0);
        chk("rm_rst.rvalid", {31'b0, rvalid_o}, 32'h0);
        chk("rm_rst.rdata",  rdata_o,           32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, "rm_rel0");
        step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, "rm_rel1");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
